multicycle_control_fsm: RTL

- Multicycle MIPS control unit that sequences the shared datapath: PC, unified memory, register file and ALU.
- Consumes `op`/`func_code` from the instruction register and `zero` from the ALU; drives every datapath strobe, mux select and `alu_ctrl`.
- Waits on a memory-ready handshake.
- Keeps a retired-instruction counter and flags illegal instructions.

---
 rtl/multicycle_control_fsm.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control unit: sequences PC, unified memory, register file and ALU,
// waits on a memory-ready handshake, counts retired instructions and flags illegal ones.
module multicycle_control_fsm #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       func_code,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_ctrl,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALU_W   = 4;

    localparam logic [STATE_W-1:0] S_FETCH     = 4'd0;
    localparam logic [STATE_W-1:0] S_DECODE    = 4'd1;
    localparam logic [STATE_W-1:0] S_MEM_ADDR  = 4'd2;
    localparam logic [STATE_W-1:0] S_MEM_READ  = 4'd3;
    localparam logic [STATE_W-1:0] S_MEM_WB    = 4'd4;
    localparam logic [STATE_W-1:0] S_MEM_WRITE = 4'd5;
    localparam logic [STATE_W-1:0] S_R_EXEC    = 4'd6;
    localparam logic [STATE_W-1:0] S_R_WB      = 4'd7;
    localparam logic [STATE_W-1:0] S_BRANCH    = 4'd8;
    localparam logic [STATE_W-1:0] S_JUMP      = 4'd9;
    localparam logic [STATE_W-1:0] S_I_EXEC    = 4'd10;
    localparam logic [STATE_W-1:0] S_I_WB      = 4'd11;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_W-1:0] FN_NOR = 6'b100111;
    localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_NOR = 4'b1100;

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic [CNT_W-1:0]   r_instr_count;
    logic               r_illegal;
    logic               w_illegal;
    logic               w_retire;
    logic               w_func_ok;
    logic [ALU_W-1:0]   w_func_alu;
    logic               w_pc_write;
    logic               w_pc_write_cond;
    logic               w_mem_read;
    logic               w_mem_write;
    logic               w_ir_write;
    logic               w_reg_write;
    logic               w_unused_zero;

    // zero is combined with pc_write_cond in the datapath, not here
    assign w_unused_zero = zero;

    // R-type funct decode: legality and ALU operation
    always_comb begin
        w_func_ok  = 1'b1;
        w_func_alu = ALU_ADD;
        case (func_code)
            FN_ADD: w_func_alu = ALU_ADD;
            FN_SUB: w_func_alu = ALU_SUB;
            FN_AND: w_func_alu = ALU_AND;
            FN_OR:  w_func_alu = ALU_OR;
            FN_NOR: w_func_alu = ALU_NOR;
            FN_SLT: w_func_alu = ALU_SLT;
            default: begin
                w_func_ok  = 1'b0;
                w_func_alu = ALU_AND;
            end
        endcase
    end

    // Next-state, illegal-instruction and retirement decode
    always_comb begin
        w_next_state = S_FETCH;
        w_illegal    = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            S_FETCH:     w_next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_RTYPE: begin
                        if (w_func_ok) begin
                            w_next_state = S_R_EXEC;
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
                    OP_LW, OP_SW: w_next_state = S_MEM_ADDR;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_J:         w_next_state = S_JUMP;
                    OP_ADDI:      w_next_state = S_I_EXEC;
                    default:      w_illegal    = 1'b1;
                endcase
            end
            S_MEM_ADDR:  w_next_state = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  w_next_state = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    w_retire     = 1'b1;
            S_MEM_WRITE: begin
                w_next_state = mem_ready ? S_FETCH : S_MEM_WRITE;
                w_retire     = mem_ready;
            end
            S_R_EXEC:    w_next_state = S_R_WB;
            S_R_WB:      w_retire     = 1'b1;
            S_BRANCH:    w_retire     = 1'b1;
            S_JUMP:      w_retire     = 1'b1;
            S_I_EXEC:    w_next_state = S_I_WB;
            S_I_WB:      w_retire     = 1'b1;
            default:     w_next_state = S_FETCH;
        endcase
    end

    // Moore datapath controls per state
    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        pc_source       = 2'b00;
        i_or_d          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        reg_dst         = 1'b0;
        mem_to_reg      = 1'b0;
        w_reg_write     = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        alu_ctrl        = ALU_AND;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                alu_src_b  = 2'b01;
                alu_ctrl   = ALU_ADD;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
            end
            S_MEM_READ: begin
                w_mem_read = 1'b1;
                i_or_d     = 1'b1;
            end
            S_MEM_WB: begin
                w_reg_write = 1'b1;
                mem_to_reg  = 1'b1;
            end
            S_MEM_WRITE: begin
                w_mem_write = 1'b1;
                i_or_d      = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_ctrl  = w_func_alu;
            end
            S_R_WB: begin
                w_reg_write = 1'b1;
                reg_dst     = 1'b1;
                alu_ctrl    = w_func_alu;
            end
            S_BRANCH: begin
                alu_src_a       = 1'b1;
                alu_ctrl        = ALU_SUB;
                w_pc_write_cond = 1'b1;
                pc_source       = 2'b01;
            end
            S_JUMP: begin
                w_pc_write = 1'b1;
                pc_source  = 2'b10;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
            end
            S_I_WB: begin
                w_reg_write = 1'b1;
            end
            default: begin
                alu_ctrl = ALU_AND;
            end
        endcase
    end

    // Strobes held low for the whole time reset is asserted
    assign pc_write      = w_pc_write      & reset;
    assign pc_write_cond = w_pc_write_cond & reset;
    assign mem_read      = w_mem_read      & reset;
    assign mem_write     = w_mem_write     & reset;
    assign ir_write      = w_ir_write      & reset;
    assign reg_write     = w_reg_write     & reset;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_FETCH;
            r_instr_count <= '0;
            r_illegal     <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_illegal <= w_illegal;
            if (w_retire) begin
                r_instr_count <= r_instr_count + CNT_W'(1);
            end
        end
    end

    assign illegal_instr = r_illegal;
    assign instr_count   = r_instr_count;
    assign state         = r_state;

endmodule
